// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB PWM output stage.
//   rgb_state_e  : fade controller states (IDLE, FADE)
//   rgb_color_t  : packed r/g/b colour payload at the default duty width
//   RGB_PWM_BITS : default duty / PWM counter width
//   RGB_NUM_CH   : number of colour channels driven
package rgb_pkg;

  localparam int unsigned RGB_PWM_BITS = 8;
  localparam int unsigned RGB_NUM_CH   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } rgb_state_e;

  typedef struct packed {
    logic [RGB_PWM_BITS-1:0] r;
    logic [RGB_PWM_BITS-1:0] g;
    logic [RGB_PWM_BITS-1:0] b;
  } rgb_color_t;

endpackage : rgb_pkg

// File: rtl/rgb_pwm_channel.sv
// One PWM output channel: period-aligned shadow duty, compare against the
// shared PWM counter, registered active-low LED pin.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   pwm_cnt_i      : shared free-running PWM counter
//   period_end_i   : high in the last count of each PWM period
//   duty_i         : current duty from the fade / command logic
//   pin_o          : LED pin, 0 = lit (registered)
module rgb_pwm_channel
  import rgb_pkg::*;
#(
  parameter int unsigned PWM_BITS = RGB_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                period_end_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pin_o
);

  logic [PWM_BITS-1:0] shadow_q;
  logic                pin_q;

  // Shadow only updates at the period boundary so a period is never split
  // between two duties; the pin is lit while the counter is below the shadow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      pin_q    <= 1'b1;
    end else begin
      if (period_end_i) begin
        shadow_q <= duty_i;
      end
      pin_q <= ~(pwm_cnt_i < shadow_q);
    end
  end

  assign pin_o = pin_q;

endmodule : rgb_pwm_channel

// File: rtl/rgb_pwm_driver.sv
// RGB LED output stage: accepts colour commands over valid/ready, optionally
// ramps each channel's duty one step per STEP_INTERVAL clocks toward the
// command, and drives three active-low PWM LED pins.
// Build option: define RGB_FADE_EN to enable the linear fade (FADE state and
// step counter); without it a command loads the duties directly and
// color_ready stays high after reset.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   color_valid, color_ready : command handshake (color_ready registered)
//   color_r/g/b              : target duties
//   RGB_R/G/B                : LED pins, 0 = lit (registered)
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int unsigned PWM_BITS      = RGB_PWM_BITS,
  parameter int unsigned STEP_INTERVAL = 2000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                color_valid,
  output logic                color_ready,
  input  logic [PWM_BITS-1:0] color_r,
  input  logic [PWM_BITS-1:0] color_g,
  input  logic [PWM_BITS-1:0] color_b,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B
);

  localparam int unsigned NCH = RGB_NUM_CH;

  logic [PWM_BITS-1:0]           pwm_cnt_q;
  logic                          period_end_c;
  logic [NCH-1:0][PWM_BITS-1:0]  cmd_c;
  logic [NCH-1:0][PWM_BITS-1:0]  cur_q;
  logic [NCH-1:0][PWM_BITS-1:0]  cur_d;
  logic                          ready_q;
  logic                          ready_d;
  logic                          accept_c;
  logic [NCH-1:0]                ch_pin;

  // Channel index 0 = red, 1 = green, 2 = blue.
  assign cmd_c        = {color_b, color_g, color_r};
  assign accept_c     = color_valid && ready_q;
  assign period_end_c = (pwm_cnt_q == '1);
  assign color_ready  = ready_q;

  // Free-running PWM period counter shared by all channels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

`ifdef RGB_FADE_EN

  localparam int unsigned STEP_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_INTERVAL - 1);

  rgb_state_e                    state_q;
  rgb_state_e                    state_d;
  logic [STEP_W-1:0]             step_cnt_q;
  logic [STEP_W-1:0]             step_cnt_d;
  logic [NCH-1:0][PWM_BITS-1:0]  tgt_q;
  logic [NCH-1:0][PWM_BITS-1:0]  tgt_d;
  logic                          step_c;

  // State, step counter, target and current duty registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_cnt_q <= '0;
      tgt_q      <= '0;
      cur_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_cnt_q <= step_cnt_d;
      tgt_q      <= tgt_d;
      cur_q      <= cur_d;
      ready_q    <= ready_d;
    end
  end

  // Handshake, fade sequencing and per-channel one-step ramp.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    tgt_d      = tgt_q;
    cur_d      = cur_q;
    step_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          tgt_d      = cmd_c;
          step_cnt_d = '0;
          if (cmd_c != cur_q) begin
            state_d = FADE;
          end
        end
      end
      FADE: begin
        if (cur_q == tgt_q) begin
          state_d = IDLE;
        end else if (step_cnt_q == STEP_LAST) begin
          step_cnt_d = '0;
          step_c     = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q + STEP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Move by one toward target; a channel at its target holds, so no
    // overshoot or wrap is possible.
    if (step_c) begin
      for (int ch = 0; ch < int'(NCH); ch++) begin
        if (cur_q[ch] < tgt_q[ch]) begin
          cur_d[ch] = cur_q[ch] + PWM_BITS'(1);
        end else if (cur_q[ch] > tgt_q[ch]) begin
          cur_d[ch] = cur_q[ch] - PWM_BITS'(1);
        end
      end
    end

    ready_d = (state_d == IDLE);
  end

`else

  // Ramp interval has no meaning without fading; a zero value still shows up
  // as a marker scope in the elaborated hierarchy.
  if (STEP_INTERVAL == 0) begin : g_step_interval_zero
  end

  // Current duty and ready registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      ready_q <= ready_d;
    end
  end

  // A command loads the duties directly; ready stays high after reset.
  always_comb begin
    cur_d   = cur_q;
    ready_d = 1'b1;
    if (accept_c) begin
      cur_d = cmd_c;
    end
  end

`endif

  for (genvar ch = 0; ch < int'(NCH); ch++) begin : g_ch
    rgb_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .pwm_cnt_i    (pwm_cnt_q),
      .period_end_i (period_end_c),
      .duty_i       (cur_q[ch]),
      .pin_o        (ch_pin[ch])
    );
  end

  assign RGB_R = ch_pin[0];
  assign RGB_G = ch_pin[1];
  assign RGB_B = ch_pin[2];

endmodule : rgb_pwm_driver
